// File: rtl/cd_ctrl_pkg.sv
// Package for the cd CPU control unit.
//   - Opcode constants: the opcode[5:2] groups and the full 6-bit codes.
//   - ALU select width.
//   - PC width and the interrupt vector.
//   - ctrl_t: the bundle of datapath strobes that the decoder produces.
package cd_ctrl_pkg;

  localparam int ALU_W = 3;
  localparam int PC_W  = 10;
  localparam logic [PC_W-1:0] INT_VECTOR = 10'h384;

  // opcode[5:2] groups (any opcode with bit 5 clear is an ALU op)
  localparam logic [3:0] GRP_LI  = 4'b1000;
  localparam logic [3:0] GRP_LD  = 4'b1001;
  localparam logic [3:0] GRP_ST  = 4'b1010;
  localparam logic [3:0] GRP_IN  = 4'b1011;
  localparam logic [3:0] GRP_OUT = 4'b1100;

  // Full opcodes
  localparam logic [5:0] OP_TIMER = 6'b110100;
  localparam logic [5:0] OP_EI    = 6'b110101;
  localparam logic [5:0] OP_DI    = 6'b110110;
  localparam logic [5:0] OP_KEY   = 6'b110111;
  localparam logic [5:0] OP_JMP   = 6'b111000;
  localparam logic [5:0] OP_JZ    = 6'b111001;
  localparam logic [5:0] OP_JNZ   = 6'b111010;
  localparam logic [5:0] OP_CALL  = 6'b111011;
  localparam logic [5:0] OP_RET   = 6'b111100;
  localparam logic [5:0] OP_RETI  = 6'b111101;
  localparam logic [5:0] OP_NOP0  = 6'b111110;
  localparam logic [5:0] OP_NOP1  = 6'b111111;

  typedef struct packed {
    logic             s_inc;
    logic             s_inm;
    logic             we3;
    logic             wez;
    logic             push;
    logic             pop;
    logic             s_pop;
    logic             write_enable;
    logic             s_load;
    logic             we_es;
    logic             s_cargaes;
    logic             s_interrupcion;
    logic             enable;
    logic             write_key;
    logic [ALU_W-1:0] op_alu;
    logic             int_ack;
  } ctrl_t;

  // Idle value: the PC increments and nothing is written.
  function automatic ctrl_t ctrl_idle();
    ctrl_t c;
    c       = '0;
    c.s_inc = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Interrupt request front end.
//   - Synchronises the asynchronous irq through STAGES flops.
//   - Detects rising edges of the synchronised level.
//   - Holds a pending latch that is set by an edge and cleared by clr.
//     Set wins over clear, so an edge that arrives in the same cycle as the
//     interrupt being taken is not lost.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   irq                asynchronous request level
//   clr                clear pending (interrupt taken this cycle)
//   rise               one-cycle pulse on a synchronised rising edge
//   pending            request latched and not yet serviced
module irq_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic irq,
  input  logic clr,
  output logic rise,
  output logic pending
);

  logic [STAGES-1:0] sync_q;
  logic              last_q;

  // Edge seen one cycle after the last synchroniser stage goes high.
  assign rise = sync_q[STAGES-1] & ~last_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      last_q  <= 1'b0;
      pending <= 1'b0;
    end else begin
      sync_q  <= {sync_q[STAGES-2:0], irq};
      last_q  <= sync_q[STAGES-1];
      pending <= rise | (pending & ~clr);
    end
  end

endmodule

// File: rtl/cd_control_unit.sv
// Control unit for the single-cycle 8-bit cd datapath.
//   - Decodes opcode into the datapath strobes.
//   - Sequences interrupt entry: the current instruction is squashed, the
//     PC is pushed and the vector is loaded.
//   - Tracks return-stack depth: overflowing pushes and underflowing pops
//     are suppressed and flagged on the sticky stack_err.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   opcode              instruction[15:10]
//   z                   registered zero flag
//   irq                 asynchronous interrupt request (rising edge)
//   s_inc .. write_key  datapath strobes and selects
//   op_alu              ALU operation
//   int_ack             high in the interrupt-entry cycle
//   ie                  interrupt-enable flag
//   stack_err           sticky stack overflow / underflow flag
module cd_control_unit
  import cd_ctrl_pkg::*;
#(
  parameter int STACK_DEPTH     = 16,
  parameter int IRQ_SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             z,
  input  logic             irq,
  output logic             s_inc,
  output logic             s_inm,
  output logic             we3,
  output logic             wez,
  output logic             push,
  output logic             pop,
  output logic             s_pop,
  output logic             write_enable,
  output logic             s_load,
  output logic             we_es,
  output logic             s_cargaes,
  output logic             s_interrupcion,
  output logic             enable,
  output logic             write_key,
  output logic [ALU_W-1:0] op_alu,
  output logic             int_ack,
  output logic             ie,
  output logic             stack_err
);

  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam logic [DW-1:0] DEPTH_MAX = DW'(STACK_DEPTH);

  logic [DW-1:0] depth;
  logic          inhibit;
  logic          pending;
  logic          rise;
  logic          take;
  logic          full, empty;
  logic          is_call, is_popop, is_ei, is_di, is_reti;
  logic          ovf, udf;
  ctrl_t         c;

  irq_sync_edge #(.STAGES(IRQ_SYNC_STAGES)) u_irq (
    .clk     (clk),
    .reset   (reset),
    .irq     (irq),
    .clr     (take),
    .rise    (rise),
    .pending (pending)
  );

  assign full  = (depth == DEPTH_MAX);
  assign empty = (depth == '0);
  assign take  = pending & ie & ~inhibit & ~reset;

  // Decode plus interrupt override. Everything is gated by reset so the
  // datapath sees an idle, incrementing PC while reset is held.
  always_comb begin
    c         = ctrl_idle();
    is_call   = 1'b0;
    is_popop  = 1'b0;
    is_ei     = 1'b0;
    is_di     = 1'b0;
    is_reti   = 1'b0;
    ovf       = 1'b0;
    udf       = 1'b0;
    if (!reset) begin
      is_call  = (opcode == OP_CALL);
      is_popop = (opcode == OP_RET) || (opcode == OP_RETI);
      is_ei    = (opcode == OP_EI);
      is_di    = (opcode == OP_DI);
      is_reti  = (opcode == OP_RETI);

      if (!opcode[5]) begin
        c.op_alu = opcode[4:2];
        c.we3    = 1'b1;
        c.wez    = 1'b1;
      end else begin
        case (opcode[5:2])
          GRP_LI:  begin c.s_inm     = 1'b1; c.we3 = 1'b1; end
          GRP_LD:  begin c.s_load    = 1'b1; c.we3 = 1'b1; end
          GRP_ST:  c.write_enable = 1'b1;
          GRP_IN:  begin c.s_cargaes = 1'b1; c.we3 = 1'b1; end
          GRP_OUT: c.we_es = 1'b1;
          default: ;
        endcase
        case (opcode)
          OP_TIMER: c.enable    = 1'b1;
          OP_KEY:   c.write_key = 1'b1;
          OP_JMP:   c.s_inc     = 1'b0;
          OP_JZ:    c.s_inc     = ~z;
          OP_JNZ:   c.s_inc     = z;
          OP_CALL: begin
            // A full stack still jumps; only the push is dropped.
            c.s_inc = 1'b0;
            c.push  = ~full;
          end
          OP_RET, OP_RETI: begin
            // An empty stack falls through instead of popping garbage.
            c.pop   = ~empty;
            c.s_pop = ~empty;
          end
          default: ;
        endcase
      end

      if (take) begin
        // Squash every architectural write of the current instruction;
        // its PC is pushed so it re-executes after RETI.
        c.we3            = 1'b0;
        c.wez            = 1'b0;
        c.write_enable   = 1'b0;
        c.we_es          = 1'b0;
        c.enable         = 1'b0;
        c.write_key      = 1'b0;
        c.pop            = 1'b0;
        c.s_pop          = 1'b0;
        c.push           = ~full;
        c.s_interrupcion = 1'b1;
        c.int_ack        = 1'b1;
      end

      ovf = (take | is_call) & full;
      udf = ~take & is_popop & empty;
    end
  end

  assign s_inc          = c.s_inc;
  assign s_inm          = c.s_inm;
  assign we3            = c.we3;
  assign wez            = c.wez;
  assign push           = c.push;
  assign pop            = c.pop;
  assign s_pop          = c.s_pop;
  assign write_enable   = c.write_enable;
  assign s_load         = c.s_load;
  assign we_es          = c.we_es;
  assign s_cargaes      = c.s_cargaes;
  assign s_interrupcion = c.s_interrupcion;
  assign enable         = c.enable;
  assign write_key      = c.write_key;
  assign op_alu         = c.op_alu;
  assign int_ack        = c.int_ack;

  always_ff @(posedge clk) begin
    if (reset) begin
      ie        <= 1'b0;
      inhibit   <= 1'b0;
      depth     <= '0;
      stack_err <= 1'b0;
    end else begin
      // A taken interrupt squashes EI/DI/RETI effects of the instruction.
      if (take)                ie <= 1'b0;
      else if (is_ei|is_reti)  ie <= 1'b1;
      else if (is_di)          ie <= 1'b0;

      // Guarantees one instruction after EI/RETI before the next entry.
      inhibit <= ~take & (is_ei | is_reti);

      if (c.push)     depth <= depth + DW'(1);
      else if (c.pop) depth <= depth - DW'(1);

      if (ovf | udf) stack_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cd_control_unit.sv
// Bench for cd_control_unit: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a behavioural model.
module tb_cd_control_unit;

  localparam int DEPTH  = 16;
  localparam int STAGES = 2;

  localparam logic [5:0] NOP  = 6'h3E;
  localparam logic [5:0] EI   = 6'h35;
  localparam logic [5:0] DI   = 6'h36;
  localparam logic [5:0] CALL = 6'h3B;
  localparam logic [5:0] RET  = 6'h3C;
  localparam logic [5:0] RETI = 6'h3D;
  localparam logic [5:0] JZ   = 6'h39;
  localparam logic [5:0] ALU3 = 6'b001100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = NOP;
  logic       z = 1'b0;
  logic       irq = 1'b0;

  logic s_inc, s_inm, we3, wez, push, pop, s_pop, write_enable, s_load, we_es;
  logic s_cargaes, s_interrupcion, enable, write_key, int_ack, ie, stack_err;
  logic [2:0] op_alu;

  cd_control_unit #(.STACK_DEPTH(DEPTH), .IRQ_SYNC_STAGES(STAGES)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .z(z), .irq(irq),
    .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez), .push(push),
    .pop(pop), .s_pop(s_pop), .write_enable(write_enable), .s_load(s_load),
    .we_es(we_es), .s_cargaes(s_cargaes), .s_interrupcion(s_interrupcion),
    .enable(enable), .write_key(write_key), .op_alu(op_alu),
    .int_ack(int_ack), .ie(ie), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  logic [19:0] dut_vec;
  assign dut_vec = {s_inc, s_inm, we3, wez, push, pop, s_pop, write_enable,
                    s_load, we_es, s_cargaes, s_interrupcion, enable,
                    write_key, op_alu, int_ack, ie, stack_err};

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  bit m_ie, m_inh, m_pend, m_err;
  int m_depth;
  bit hq [0:STAGES];   // hq[k] = irq sampled at the (k+1)-th previous edge

  task automatic model_cycle();
    bit e_sinc, e_inm, e_we3, e_wez, e_push, e_pop, e_spop, e_wr, e_load;
    bit e_wees, e_ces, e_sint, e_en, e_key, e_ack;
    bit [2:0] e_alu;
    bit take, call, popop, ei, di, reti, rise;
    int op, grp;
    logic [19:0] exp;
    e_sinc = 1; {e_inm, e_we3, e_wez, e_push, e_pop, e_spop, e_wr, e_load} = '0;
    {e_wees, e_ces, e_sint, e_en, e_key, e_ack} = '0; e_alu = 0;
    take = 0; call = 0; popop = 0; ei = 0; di = 0; reti = 0;
    op = int'(opcode); grp = op / 4;
    if (!reset) begin
      take  = m_pend && m_ie && !m_inh;
      call  = (op == 'h3B); popop = (op == 'h3C || op == 'h3D);
      ei    = (op == 'h35); di = (op == 'h36); reti = (op == 'h3D);
      if (op < 32) begin e_alu = 3'(grp % 8); e_we3 = 1; e_wez = 1; end
      else if (grp == 8)  begin e_inm = 1; e_we3 = 1; end
      else if (grp == 9)  begin e_load = 1; e_we3 = 1; end
      else if (grp == 10) e_wr = 1;
      else if (grp == 11) begin e_ces = 1; e_we3 = 1; end
      else if (grp == 12) e_wees = 1;
      if (op == 'h34) e_en = 1;
      if (op == 'h37) e_key = 1;
      if (op == 'h38) e_sinc = 0;
      if (op == 'h39) e_sinc = !z;
      if (op == 'h3A) e_sinc = z;
      if (call) begin e_sinc = 0; e_push = (m_depth < DEPTH); end
      if (popop && m_depth > 0) begin e_pop = 1; e_spop = 1; end
      if (take) begin
        {e_we3, e_wez, e_wr, e_wees, e_en, e_key, e_pop, e_spop} = '0;
        e_push = (m_depth < DEPTH); e_sint = 1; e_ack = 1;
      end
    end
    exp = {e_sinc, e_inm, e_we3, e_wez, e_push, e_pop, e_spop, e_wr, e_load,
           e_wees, e_ces, e_sint, e_en, e_key, e_alu, e_ack, m_ie, m_err};
    chk($sformatf("model op=%02h", opcode), 32'(dut_vec), 32'(exp));

    // state after the coming edge
    if (reset) begin
      m_ie = 0; m_inh = 0; m_pend = 0; m_err = 0; m_depth = 0;
      for (int i = 0; i <= STAGES; i++) hq[i] = 0;
    end else begin
      rise = hq[STAGES-1] && !hq[STAGES];
      if (take) begin
        if (m_depth < DEPTH) m_depth++; else m_err = 1;
        m_ie = 0; m_inh = 0; m_pend = rise;
      end else begin
        m_pend = m_pend || rise;
        if (call)  begin if (m_depth < DEPTH) m_depth++; else m_err = 1; end
        if (popop) begin if (m_depth > 0) m_depth--; else m_err = 1; end
        if (ei || reti) m_ie = 1; else if (di) m_ie = 0;
        m_inh = ei || reti;
      end
      for (int i = STAGES; i > 0; i--) hq[i] = hq[i-1];
      hq[0] = irq;
    end
  endtask

  initial begin
    for (int i = 0; i <= STAGES; i++) hq[i] = 0;
    forever begin
      @(negedge clk);
      #2;
      model_cycle();
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic [5:0] op, input logic zz, input logic ii);
    @(negedge clk);
    reset = 1'b0; opcode = op; z = zz; irq = ii;
    #3;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset = 1'b1; opcode = CALL; z = 1'b0; irq = 1'b0;
      #3;
      chk("reset s_inc", s_inc, 1);
      chk("reset push", push, 0);
    end
  endtask

  initial begin
    do_reset(2);

    // decode pins
    step(NOP, 0, 0);  chk("rst ie", ie, 0); chk("rst err", stack_err, 0); chk("nop s_inc", s_inc, 1);
    step(ALU3, 0, 0); chk("alu op", op_alu, 3'b011); chk("alu we3", we3, 1); chk("alu wez", wez, 1);
    step(JZ, 1, 0);   chk("jz z1", s_inc, 0);
    step(JZ, 0, 0);   chk("jz z0", s_inc, 1);
    for (int o = 0; o < 64; o++) begin
      if (6'(o) != EI && 6'(o) != CALL && 6'(o) != RET && 6'(o) != RETI) begin
        step(6'(o), 0, 0);
        step(6'(o), 1, 0);
      end
    end

    // interrupt latency and entry
    step(EI, 0, 0);
    step(ALU3, 0, 1);                       // irq sampled high at edge t
    step(ALU3, 0, 1); chk("lat t+0 ack", int_ack, 0);
    step(ALU3, 0, 1); chk("lat t+1 ack", int_ack, 0);
    step(ALU3, 0, 1); chk("entry ack", int_ack, 1); chk("entry push", push, 1);
    chk("entry sint", s_interrupcion, 1); chk("entry we3", we3, 0); chk("entry wez", wez, 0);
    step(NOP, 0, 1);  chk("post ie", ie, 0); chk("post ack", int_ack, 0);

    // masked, then EI inhibit
    step(NOP, 0, 0); step(NOP, 0, 0);
    for (int i = 0; i < 5; i++) begin step(NOP, 0, 1); chk("masked ack", int_ack, 0); end
    step(EI, 0, 1);  chk("ei ack", int_ack, 0);
    step(NOP, 0, 1); chk("inhibit ack", int_ack, 0);
    step(NOP, 0, 1); chk("after ei ack", int_ack, 1);

    // RETI with a pending request
    step(NOP, 0, 0); step(NOP, 0, 0);
    for (int i = 0; i < 4; i++) step(NOP, 0, 1);
    step(RETI, 0, 1); chk("reti ack", int_ack, 0); chk("reti pop", pop, 1);
    step(NOP, 0, 1);  chk("reti inh ack", int_ack, 0); chk("reti ie", ie, 1);
    step(NOP, 0, 1);  chk("reti+2 ack", int_ack, 1);
    step(NOP, 0, 0);

    // overflow
    do_reset(1);
    for (int i = 0; i < DEPTH; i++) begin step(CALL, 0, 0); chk("call push", push, 1); end
    step(NOP, 0, 0);  chk("full err", stack_err, 0);
    step(CALL, 0, 0); chk("ovf push", push, 0); chk("ovf s_inc", s_inc, 0);
    step(NOP, 0, 0);  chk("ovf err", stack_err, 1);
    step(RET, 0, 0);  step(NOP, 0, 0); step(NOP, 0, 0); chk("err sticky", stack_err, 1);

    // underflow
    do_reset(1);
    step(RET, 0, 0); chk("udf pop", pop, 0); chk("udf s_pop", s_pop, 0); chk("udf s_inc", s_inc, 1);
    step(NOP, 0, 0); chk("udf err", stack_err, 1);

    // reset mid-operation: pending, ie, depth 5
    do_reset(1);
    for (int i = 0; i < 5; i++) step(CALL, 0, 0);
    step(NOP, 0, 1);
    for (int i = 0; i < 4; i++) step(NOP, 0, 0);
    step(EI, 0, 0);
    do_reset(1);
    for (int i = 0; i < 6; i++) begin step(NOP, 0, 0); chk("mid rst ack", int_ack, 0); end
    step(RET, 0, 0); chk("mid rst depth0", pop, 0);
    step(EI, 0, 0);
    for (int i = 0; i < 4; i++) begin step(NOP, 0, 0); chk("no stale req", int_ack, 0); end
    step(NOP, 0, 1); step(NOP, 0, 1); step(NOP, 0, 1);
    step(NOP, 0, 1); chk("fresh edge ack", int_ack, 1);

    // randomized traffic
    do_reset(1);
    begin
      logic il;
      logic [5:0] op;
      int r;
      il = 1'b0;
      for (int n = 0; n < 4000; n++) begin
        if ($urandom_range(0, 7) == 0) il = ~il;
        r = $urandom_range(0, 11);
        if (r < 2)       op = EI;
        else if (r == 2) op = RETI;
        else if (r == 3) op = CALL;
        else if (r == 4) op = DI;
        else             op = 6'($urandom);
        if ($urandom_range(0, 299) == 0) do_reset(1);
        else step(op, 1'($urandom), il);
      end
    end

    step(NOP, 0, 0);
    @(negedge clk); #4;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/cd_control_unit.md
Name: cd_control_unit

Overview:
- Control unit for the 8-bit CPU datapath `cd`.
- Decodes `opcode` and drives every datapath control strobe.
- Sequences interrupt entry and return: irq synchronisation, edge detect, pending latch, enable flag and one-cycle inhibit.
- Tracks return-stack depth, suppressing stack overflow and underflow and flagging them with a sticky error.
- Single-cycle datapath: the PC loads every clock, so interrupt entry squashes the current instruction.

Parameters:
STACK_DEPTH, 16, return-stack entries; the depth counter saturates at this value.
IRQ_SYNC_STAGES, 2, synchroniser flops on `irq`; minimum 2.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
opcode  in  6  instruction[15:10]
z  in  1  registered zero flag
irq  in  1  asynchronous interrupt request; a rising edge is the request
s_inc, s_inm, we3, wez, push, pop, s_pop, write_enable, s_load, we_es, s_cargaes, s_interrupcion, enable, write_key  out  1 each  datapath controls
op_alu  out  3  ALU operation select
int_ack  out  1  high in the interrupt-entry cycle
ie  out  1  interrupt-enable flag
stack_err  out  1  sticky stack overflow or underflow flag

Behaviour:
- Clock and reset: one clock `clk`; `reset` is synchronous and active-high.
- Reset values: ie=0, pending=0, inhibit=0, depth=0, stack_err=0, synchroniser flops=0.
- Outputs while reset=1: all write/strobe outputs 0, s_inc=1, every other select 0, op_alu=000.
- Default when no rule applies: s_inc=1, all other outputs 0.
- Decode, opcode[5:2] group:
  - 0xxx: ALU op. op_alu=opcode[4:2], we3=1, wez=1.
  - 1000: load immediate. s_inm=1, we3=1.
  - 1001: load memory. s_load=1, we3=1.
  - 1010: store memory. write_enable=1.
  - 1011: IN. s_cargaes=1, we3=1.
  - 1100: OUT. we_es=1.
- Decode, full opcode:
  - 110100: timer config, enable=1.
  - 110101: EI. Sets ie=1 and sets inhibit for 1 cycle.
  - 110110: DI. Clears ie=0.
  - 110111: keylog write, write_key=1.
  - 111000: JMP, s_inc=0.
  - 111001: JZ, s_inc=~z.
  - 111010: JNZ, s_inc=z.
  - 111011: CALL. s_inc=0, push=1.
  - 111100: RET. pop=1, s_pop=1.
  - 111101: RETI. Same as RET, plus ie=1 and inhibit set for 1 cycle.
  - 111110, 111111: NOP.
- IRQ path:
  - `irq` passes through IRQ_SYNC_STAGES flops, then a rising-edge detector sets `pending`.
  - With 2 stages, irq sampled high at edge t gives pending=1 after edge t+2.
  - Further edges while pending=1 are merged.
- Take condition: pending & ie & ~inhibit & ~reset, evaluated combinationally each cycle.
- Interrupt entry, in the taken cycle:
  - The current instruction is squashed: all of we3, wez, write_enable, we_es, enable, write_key, pop and s_pop are forced to 0.
  - push=1, which saves the current PC so the squashed instruction re-executes after RETI.
  - s_interrupcion=1, loading vector 10'h384.
  - int_ack=1.
  - At the clock edge: pending=0, ie=0.
- Same-cycle interactions:
  - A new irq edge detected in the taken cycle re-sets pending; the edge is not lost.
  - DI in the taken cycle is squashed, so the interrupt wins.
  - EI or RETI cannot be followed by an interrupt in the next cycle because of the inhibit.
- Depth counter:
  - Push (CALL or interrupt entry) increments it; pop (RET or RETI) decrements it.
  - It saturates at 0 and STACK_DEPTH and never wraps.
- Overflow (push requested at depth==STACK_DEPTH):
  - push forced 0 and stack_err set.
  - CALL still jumps (s_inc=0).
  - Interrupt entry still vectors and clears pending.
- Underflow (RET or RETI at depth==0):
  - pop=0, s_pop=0, s_inc=1, so the PC falls through.
  - stack_err set.
  - RETI still sets ie.
- stack_err clears only on reset.
- Reset mid-sequence: all state is cleared on the reset edge, including a pending request; no request survives reset.

Decomposition:
- Package `cd_ctrl_pkg` holds:
  - opcode constants for the groups and full codes above;
  - the ALU op width (3);
  - the interrupt vector 10'h384 and the PC width (10).
- Sub-module `irq_sync_edge` contains the parameterised synchroniser, the rising-edge detector and the pending latch with set/clear inputs.
- Decode, interrupt and depth logic stay in `cd_control_unit`.

Test Plan:
- Decode sweep: drive each opcode in turn (z=0 and z=1) with no irq -> every output matches the decode list. For example, 6'b001100 gives op_alu=011, we3=1, wez=1; JZ with z=1 gives s_inc=0.
- IRQ latency and entry: EI, then irq 0->1 at edge t with an ALU op pending -> int_ack=1 in cycle t+2 (2 stages); in that cycle push=1, s_interrupcion=1, we3=0, wez=0. Next cycle ie=0 and pending=0.
- Masking and inhibit:
  - irq pulse with ie=0 -> no entry; pending stays 1.
  - EI -> no entry in the cycle right after EI; entry one cycle later.
  - RETI with pending=1 -> entry exactly 2 cycles after RETI.
- Overflow: 16 CALLs -> depth=16, stack_err=0. 17th CALL -> push=0, s_inc=0, stack_err=1, and it stays 1 until reset.
- Underflow: RET at depth 0 -> pop=0, s_pop=0, s_inc=1, stack_err=1.
- Reset mid-operation: pending=1, ie=1, depth=5, then reset for 1 cycle -> ie=0, pending=0, depth=0, no int_ack after release; a fresh irq edge is needed for entry.
